// File: rtl/fetch_stage.sv
// Fetch stage of the pipelined MIPS core: owns PC_F, computes the next PC from the
// instruction held in ID, and fills the IF/ID register, flagging out-of-window fetches.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        branch_cond,
  input  logic [31:0] rs_data_D,
  input  logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        fault_D
);

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  // One bit wider than the PC so a window ending at 2^32 still compares correctly.
  localparam logic [32:0] WIN_END = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

  logic [31:0] r_pc_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic        r_fault_d;

  logic [31:0] w_pc_f_plus4;
  logic [31:0] w_pc_d_plus4;
  logic [31:0] w_br_offset;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_next_pc;
  logic        w_illegal;

  assign w_pc_f_plus4 = r_pc_f + 32'd4;
  assign w_pc_d_plus4 = r_pc_d + 32'd4;
  assign w_br_offset  = {{14{r_instr_d[15]}}, r_instr_d[15:0], 2'b00};
  assign w_br_target  = w_pc_d_plus4 + w_br_offset;
  assign w_j_target   = {w_pc_d_plus4[31:28], r_instr_d[25:0], 2'b00};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next_pc = w_pc_f_plus4;
    case (npc_sel_e'(npc_sel))
      NPC_SEQ: w_next_pc = w_pc_f_plus4;
      NPC_BR:  w_next_pc = branch_cond ? w_br_target : w_pc_f_plus4;
      NPC_J:   w_next_pc = w_j_target;
      NPC_JR:  w_next_pc = rs_data_D;
      default: w_next_pc = w_pc_f_plus4;
    endcase
  end

  assign w_illegal = (r_pc_f[1:0] != 2'b00)
                  || (r_pc_f < RESET_PC)
                  || ({1'b0, r_pc_f} >= WIN_END);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // The delay slot is never squashed: IF always moves into ID on an unstalled edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc_f    <= RESET_PC;
      r_instr_d <= 32'd0;
      r_pc_d    <= 32'd0;
      r_fault_d <= 1'b0;
    end else if (!stall) begin
      r_pc_f    <= w_next_pc;
      r_instr_d <= w_illegal ? 32'd0 : Instr_F;
      r_pc_d    <= r_pc_f;
      r_fault_d <= w_illegal;
    end
  end

  assign PC_F    = r_pc_f;
  assign Instr_D = r_instr_d;
  assign PC_D    = r_pc_d;
  assign PC8_D   = r_pc_d + 32'd8;
  assign fault_D = r_fault_d;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: the bench plays instruction memory and ID decoder,
// queues the expected IF/ID state per edge and compares it once the edge has happened.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_sel;
  logic        branch_cond;
  logic [31:0] rs_data_D;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] PC8_D;
  logic        fault_D;

  typedef struct packed {
    logic [31:0] pc_f;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        fault;
  } exp_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic        cond;
    logic [31:0] rs;
    logic        st;
    logic [31:0] pc_f;
    logic [31:0] pc_d;
  } stim_t;

  logic [31:0] mem [0:4095];
  exp_t        sb [$];
  int          n_run;
  int          n_fail;

  fetch_stage #(.RESET_PC(32'h0000_3000), .IM_WORDS(4096)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .npc_sel    (npc_sel),
    .branch_cond(branch_cond),
    .rs_data_D  (rs_data_D),
    .Instr_F    (Instr_F),
    .PC_F       (PC_F),
    .Instr_D    (Instr_D),
    .PC_D       (PC_D),
    .PC8_D      (PC8_D),
    .fault_D    (fault_D)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: out-of-window reads return junk so the nop substitution is visible.
  always_comb begin
    logic [31:0] off;
    off = PC_F - 32'h3000;
    if (PC_F[1:0] == 2'b00 && PC_F >= 32'h3000 && PC_F < 32'h7000)
      Instr_F = mem[off[13:2]];
    else
      Instr_F = 32'hDEAD_BEEF;
  end

  function automatic exp_t obs();
    return '{PC_F, Instr_D, PC_D, PC8_D, fault_D};
  endfunction

  // Expected IF/ID contents after an edge that fetched from pc_d and moved PC_F to pc_f.
  function automatic exp_t mk(logic [31:0] pc_f, logic [31:0] pc_d);
    exp_t        e;
    logic        ok;
    logic [31:0] off;
    ok      = (pc_d[1:0] == 2'b00) && (pc_d >= 32'h3000) && (pc_d < 32'h7000);
    off     = pc_d - 32'h3000;
    e.pc_f  = pc_f;
    e.pc_d  = pc_d;
    e.pc8_d = pc_d + 32'd8;
    e.fault = !ok;
    e.instr_d = ok ? mem[off[13:2]] : 32'd0;
    return e;
  endfunction

  task automatic mem_init();
    for (int i = 0; i < 4096; i++) mem[i] = 32'h2400_0000 | 32'(i);
  endtask

  task automatic do_reset();
    reset = 1'b0; stall = 1'b0; npc_sel = 2'b00; branch_cond = 1'b0; rs_data_D = 32'd0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step(logic [1:0] sel, logic cond, logic [31:0] rs, logic st);
    npc_sel = sel; branch_cond = cond; rs_data_D = rs; stall = st;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t tbl [$];
    exp_t  e;
    mem_init();
    mem[0] = 32'h3C01_0001; mem[1] = 32'h3421_0002; mem[2] = 32'h0000_0000;
    reset = 1'b0; stall = 1'b0; npc_sel = 2'b00; branch_cond = 1'b0; rs_data_D = 32'd0;
    #1;
    sb.push_back('{32'h3000, 32'd0, 32'd0, 32'd8, 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin
      n_fail++; $display("FAIL reset_values: got %h exp %h", obs(), e);
    end
    @(negedge clk);
    reset = 1'b1;
    tbl.push_back('{2'b00, 1'b0, 32'h0, 1'b0, 32'h3004, 32'h3000});
    tbl.push_back('{2'b00, 1'b0, 32'h0, 1'b0, 32'h3008, 32'h3004});
    tbl.push_back('{2'b00, 1'b0, 32'h0, 1'b0, 32'h300C, 32'h3008});
    foreach (tbl[i]) begin
      sb.push_back(mk(tbl[i].pc_f, tbl[i].pc_d));
      step(tbl[i].sel, tbl[i].cond, tbl[i].rs, tbl[i].st);
      e = sb.pop_front(); n_run++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL sequential[%0d]: got %h exp %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_branch(logic [31:0] br_word, logic taken, logic [31:0] target);
    stim_t tbl [$];
    exp_t  e;
    mem_init();
    mem[1] = br_word;
    mem[2] = 32'h2442_0001;
    do_reset();
    tbl.push_back('{2'b00, 1'b0, 32'h0, 1'b0, 32'h3004, 32'h3000});
    tbl.push_back('{2'b00, 1'b0, 32'h0, 1'b0, 32'h3008, 32'h3004});
    tbl.push_back('{2'b01, taken, 32'h0, 1'b0, target, 32'h3008});
    tbl.push_back('{2'b00, 1'b0, 32'h0, 1'b0, target + 32'd4, target});
    foreach (tbl[i]) begin
      sb.push_back(mk(tbl[i].pc_f, tbl[i].pc_d));
      step(tbl[i].sel, tbl[i].cond, tbl[i].rs, tbl[i].st);
      e = sb.pop_front(); n_run++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL branch_%h_%b[%0d]: got %h exp %h", br_word, taken, i, obs(), e);
      end
    end
  endtask

  task automatic test_jump();
    stim_t tbl [$];
    exp_t  e;
    mem_init();
    mem[1] = 32'h0800_0C40;
    do_reset();
    tbl.push_back('{2'b00, 1'b0, 32'h0,    1'b0, 32'h3004, 32'h3000});
    tbl.push_back('{2'b00, 1'b0, 32'h0,    1'b0, 32'h3008, 32'h3004});
    tbl.push_back('{2'b10, 1'b0, 32'h0,    1'b0, 32'h3100, 32'h3008});
    tbl.push_back('{2'b11, 1'b1, 32'h3200, 1'b0, 32'h3200, 32'h3100});
    tbl.push_back('{2'b00, 1'b0, 32'h0,    1'b0, 32'h3204, 32'h3200});
    foreach (tbl[i]) begin
      sb.push_back(mk(tbl[i].pc_f, tbl[i].pc_d));
      step(tbl[i].sel, tbl[i].cond, tbl[i].rs, tbl[i].st);
      e = sb.pop_front(); n_run++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL jump[%0d]: got %h exp %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_stall();
    stim_t tbl [$];
    exp_t  e;
    mem_init();
    do_reset();
    tbl.push_back('{2'b00, 1'b0, 32'h0,    1'b0, 32'h3004, 32'h3000});
    tbl.push_back('{2'b00, 1'b0, 32'h0,    1'b0, 32'h3008, 32'h3004});
    tbl.push_back('{2'b11, 1'b0, 32'h3200, 1'b1, 32'h3008, 32'h3004});
    tbl.push_back('{2'b11, 1'b0, 32'h3200, 1'b1, 32'h3008, 32'h3004});
    tbl.push_back('{2'b11, 1'b0, 32'h3200, 1'b0, 32'h3200, 32'h3008});
    tbl.push_back('{2'b00, 1'b0, 32'h0,    1'b0, 32'h3204, 32'h3200});
    foreach (tbl[i]) begin
      sb.push_back(mk(tbl[i].pc_f, tbl[i].pc_d));
      step(tbl[i].sel, tbl[i].cond, tbl[i].rs, tbl[i].st);
      e = sb.pop_front(); n_run++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL stall[%0d]: got %h exp %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_illegal();
    stim_t tbl [$];
    exp_t  e;
    mem_init();
    do_reset();
    tbl.push_back('{2'b00, 1'b0, 32'h0,    1'b0, 32'h3004, 32'h3000});
    tbl.push_back('{2'b11, 1'b0, 32'h3002, 1'b0, 32'h3002, 32'h3004});
    tbl.push_back('{2'b00, 1'b0, 32'h0,    1'b0, 32'h3006, 32'h3002});
    tbl.push_back('{2'b11, 1'b0, 32'h3010, 1'b0, 32'h3010, 32'h3006});
    tbl.push_back('{2'b00, 1'b0, 32'h0,    1'b0, 32'h3014, 32'h3010});
    tbl.push_back('{2'b11, 1'b0, 32'h7000, 1'b0, 32'h7000, 32'h3014});
    tbl.push_back('{2'b00, 1'b0, 32'h0,    1'b0, 32'h7004, 32'h7000});
    tbl.push_back('{2'b11, 1'b0, 32'h6FFC, 1'b0, 32'h6FFC, 32'h7004});
    tbl.push_back('{2'b00, 1'b0, 32'h0,    1'b0, 32'h7000, 32'h6FFC});
    tbl.push_back('{2'b11, 1'b0, 32'h2FFC, 1'b0, 32'h2FFC, 32'h7000});
    tbl.push_back('{2'b00, 1'b0, 32'h0,    1'b0, 32'h3000, 32'h2FFC});
    tbl.push_back('{2'b00, 1'b0, 32'h0,    1'b0, 32'h3004, 32'h3000});
    foreach (tbl[i]) begin
      sb.push_back(mk(tbl[i].pc_f, tbl[i].pc_d));
      step(tbl[i].sel, tbl[i].cond, tbl[i].rs, tbl[i].st);
      e = sb.pop_front(); n_run++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL illegal[%0d]: got %h exp %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_wrap();
    stim_t tbl [$];
    exp_t  e;
    mem_init();
    do_reset();
    tbl.push_back('{2'b11, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 32'h3000});
    tbl.push_back('{2'b00, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 32'hFFFF_FFFC});
    tbl.push_back('{2'b11, 1'b0, 32'h3000,      1'b0, 32'h3000,      32'h0000_0000});
    tbl.push_back('{2'b00, 1'b0, 32'h0,         1'b0, 32'h3004,      32'h3000});
    foreach (tbl[i]) begin
      sb.push_back(mk(tbl[i].pc_f, tbl[i].pc_d));
      step(tbl[i].sel, tbl[i].cond, tbl[i].rs, tbl[i].st);
      e = sb.pop_front(); n_run++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL wrap[%0d]: got %h exp %h", i, obs(), e);
      end
    end
  endtask

  // A jump sitting in a taken branch's delay slot redirects in turn.
  task automatic test_back_to_back();
    stim_t tbl [$];
    exp_t  e;
    mem_init();
    mem[1] = 32'h1000_0003;
    mem[2] = 32'h0800_0C80;
    do_reset();
    tbl.push_back('{2'b00, 1'b0, 32'h0, 1'b0, 32'h3004, 32'h3000});
    tbl.push_back('{2'b00, 1'b0, 32'h0, 1'b0, 32'h3008, 32'h3004});
    tbl.push_back('{2'b01, 1'b1, 32'h0, 1'b0, 32'h3014, 32'h3008});
    tbl.push_back('{2'b10, 1'b0, 32'h0, 1'b0, 32'h3200, 32'h3014});
    tbl.push_back('{2'b00, 1'b0, 32'h0, 1'b0, 32'h3204, 32'h3200});
    foreach (tbl[i]) begin
      sb.push_back(mk(tbl[i].pc_f, tbl[i].pc_d));
      step(tbl[i].sel, tbl[i].cond, tbl[i].rs, tbl[i].st);
      e = sb.pop_front(); n_run++;
      if (obs() !== e) begin
        n_fail++; $display("FAIL back_to_back[%0d]: got %h exp %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    mem_init();
    mem[1] = 32'h1000_0003;
    do_reset();
    step(2'b00, 1'b0, 32'h0, 1'b0);
    step(2'b00, 1'b0, 32'h0, 1'b0);
    sb.push_back(mk(32'h3008, 32'h3004));
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin
      n_fail++; $display("FAIL mid_reset_pre: got %h exp %h", obs(), e);
    end
    npc_sel = 2'b01; branch_cond = 1'b1;
    #3;
    sb.push_back('{32'h3000, 32'd0, 32'd0, 32'd8, 1'b0});
    reset = 1'b0;
    #1;
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin
      n_fail++; $display("FAIL mid_reset_async: got %h exp %h", obs(), e);
    end
    sb.push_back('{32'h3000, 32'd0, 32'd0, 32'd8, 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin
      n_fail++; $display("FAIL mid_reset_held: got %h exp %h", obs(), e);
    end
    @(negedge clk);
    reset = 1'b1;
    sb.push_back(mk(32'h3004, 32'h3000));
    step(2'b00, 1'b0, 32'h0, 1'b0);
    e = sb.pop_front(); n_run++;
    if (obs() !== e) begin
      n_fail++; $display("FAIL mid_reset_release: got %h exp %h", obs(), e);
    end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    reset = 1'b0; stall = 1'b0; npc_sel = 2'b00; branch_cond = 1'b0; rs_data_D = 32'd0;
    mem_init();
    test_reset();
    test_branch(32'h1000_0003, 1'b1, 32'h3014);
    test_branch(32'h1000_0003, 1'b0, 32'h300C);
    test_branch(32'h1000_FFFE, 1'b1, 32'h3000);
    test_jump();
    test_stall();
    test_illegal();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
